dose_alarm_clock: RTL
=====================

# dose_alarm_clock

Parametrised time-of-day clock with programmable dose-alarm channels, the next-generation replacement for the fixed 50 MHz second/minute/hour counter chain. It divides the system clock to a one-second tick, keeps a settable 24-hour hh:mm:ss time, and raises a latched pending flag per alarm channel when the time reaches that channel's programmed hh:mm. It sits between the board clock and the dispenser control FSM, which reads the time, acknowledges alarms and drives the displays.

## Interface
- CLK_HZ, 50000000, input clock cycles per second; prescaler terminal count is CLK_HZ-1 (minimum 2)
- N_ALARMS, 4, number of alarm channels (1..16); SEL_W = max(1, clog2(N_ALARMS))

- CLOCK_50  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  1 = timekeeping runs; 0 = prescaler and time frozen, alarm writes and acks still honoured
- set  in  1  load time from set_* this cycle
- set_hours  in  5  load value, 0..23
- set_minutes  in  6  load value, 0..59
- set_seconds  in  6  load value, 0..59
- alarm_wr  in  1  write alarm channel alarm_sel
- alarm_sel  in  SEL_W  channel index; values >= N_ALARMS ignored
- alarm_hours  in  5  alarm hour, 0..23
- alarm_minutes  in  6  alarm minute, 0..59
- alarm_en  in  1  channel armed
- ack  in  N_ALARMS  per-channel pending clear, level-sampled
- hours  out  5  current hour
- minutes  out  6  current minute
- seconds  out  6  current second
- sec_pulse  out  1  high exactly one cycle per seconds increment
- set_err  out  1  one-cycle pulse: set or alarm_wr rejected (out-of-range field)
- alarm_pending  out  N_ALARMS  latched per-channel alarm flags
- alarm_any  out  1  OR of alarm_pending (registered)

## Operation
- Prescaler counts 0..CLK_HZ-1 while enable=1; a tick occurs on the edge where it equals CLK_HZ-1 (prescaler returns to 0).
- On tick: seconds+1; 59 -> 0 carries into minutes; minutes 59 -> 0 carries into hours; hours 23 -> 0. sec_pulse=1 for the cycle after that edge, concurrent with the new time.
- set=1: if set_hours<=23, set_minutes<=59, set_seconds<=59, load time and clear prescaler; otherwise no change and set_err pulses. Set suppresses any tick on the same edge (tick lost, sec_pulse stays 0).
- Priority for time/prescaler: reset > set > tick.
- alarm_wr: if alarm_sel < N_ALARMS and fields in range, store hh:mm and en for that channel and clear its pending; out-of-range fields -> set_err, channel unchanged; alarm_sel >= N_ALARMS silently ignored.
- Match: on a tick edge whose new time is hh:mm:00 equal to an armed channel's hh:mm, that channel's pending bit sets on the same edge. Loads via set never trigger a match, even if loaded to hh:mm:00.
- Pending clears on an edge with ack[i]=1. Same-edge match and ack: match wins (stays 1). Same-edge alarm_wr and match on the written channel: write wins (pending 0, new settings used from next tick).
- Multiple channels may match the same tick; all set.
- alarm_any is the registered OR, lagging alarm_pending by one cycle.

## Timing
- All outputs and registers reset to 0 asynchronously: time 00:00:00, prescaler 0, all alarms disarmed at 00:00, pending 0, sec_pulse/set_err/alarm_any 0.
- Reset deasserted mid-second: prescaler restarts from 0; first tick exactly CLK_HZ cycles after first active edge.
- Set latency: outputs show loaded time the cycle after the set edge; next tick CLK_HZ edges after the set edge.
- enable=0 holds prescaler value; resuming continues the partial second (no restart).
- Tick-to-output latency 0 extra cycles: time, sec_pulse and pending update on the same edge.
- Full rollover 23:59:59 -> 00:00:00 in one tick.

## Test plan
- CLK_HZ=4, reset then enable=1 -> sec_pulse every 4th cycle; after 240 ticks time = 00:04:00; after 86400 ticks time wraps to 00:00:00.
- set 23:59:58, run 2 ticks -> 23:59:59 then 00:00:00, single sec_pulse each; set 24:00:00 -> set_err one cycle, time unchanged.
- Arm ch0 at 07:30 and ch2 at 07:30, set 07:29:59, one tick -> alarm_pending=0101 on that edge, alarm_any next cycle; ack=0001 -> 0100.
- ack ch1 held high on the matching tick edge -> pending[1] still 1; ack next cycle clears it.
- set 07:30:00 with ch0 armed at 07:30 -> no pending; set coincident with tick -> loaded value, no sec_pulse.
- Assert reset mid-second with pending=1111 -> all outputs 0 immediately; alarms disarmed; first sec_pulse 4 cycles after release.

Source files
------------

// File: rtl/dose_alarm_clock.sv
// Time-of-day clock (24 h hh:mm:ss) with N programmable hh:mm dose-alarm channels and latched pending flags.
// Latency: time, sec_pulse and pending update on the tick edge itself; set/alarm writes visible next cycle; alarm_any lags pending by one.
// Backpressure: none; every input is sampled each cycle, and enable=0 freezes the prescaler and time only.
module dose_alarm_clock #(
   parameter int CLK_HZ   = 50000000,
   parameter int N_ALARMS = 4,
   localparam int SEL_W   = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                enable,
   input  logic                set,
   input  logic [4:0]          set_hours,
   input  logic [5:0]          set_minutes,
   input  logic [5:0]          set_seconds,
   input  logic                alarm_wr,
   input  logic [SEL_W-1:0]    alarm_sel,
   input  logic [4:0]          alarm_hours,
   input  logic [5:0]          alarm_minutes,
   input  logic                alarm_en,
   input  logic [N_ALARMS-1:0] ack,
   output logic [4:0]          hours,
   output logic [5:0]          minutes,
   output logic [5:0]          seconds,
   output logic                sec_pulse,
   output logic                set_err,
   output logic [N_ALARMS-1:0] alarm_pending,
   output logic                alarm_any
);

   localparam int PW = $clog2(CLK_HZ);
   localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

   logic [PW-1:0] presc;
   logic          tick;
   logic          set_ok;
   logic          sel_ok;
   logic          alarm_fields_ok;
   logic          wr_ok;
   logic [4:0]    hr_nx;
   logic [5:0]    min_nx;
   logic [5:0]    sec_nx;

   logic [4:0]          al_hr  [N_ALARMS];
   logic [5:0]          al_min [N_ALARMS];
   logic [N_ALARMS-1:0] al_en;
   logic [N_ALARMS-1:0] match;

   // A set on the same edge swallows the tick, whether or not the set is accepted.
   assign tick            = enable && !set && (presc == TERM);
   assign set_ok          = (set_hours <= 5'd23) && (set_minutes <= 6'd59) && (set_seconds <= 6'd59);
   assign sel_ok          = int'({1'b0, alarm_sel}) < N_ALARMS;
   assign alarm_fields_ok = (alarm_hours <= 5'd23) && (alarm_minutes <= 6'd59);
   assign wr_ok           = alarm_wr && sel_ok && alarm_fields_ok;

   // Time after one second, with the seconds -> minutes -> hours carry chain.
   always_comb begin
      sec_nx = seconds + 6'd1;
      min_nx = minutes;
      hr_nx  = hours;
      if (seconds == 6'd59) begin
         sec_nx = 6'd0;
         min_nx = minutes + 6'd1;
         if (minutes == 6'd59) begin
            min_nx = 6'd0;
            hr_nx  = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
         end
      end
   end

   // A channel matches only when a tick lands on its hh:mm:00; loads through set never match.
   always_comb begin
      match = '0;
      for (int i = 0; i < N_ALARMS; i++) begin
         match[i] = tick && (sec_nx == 6'd0) && al_en[i] &&
                    (al_hr[i] == hr_nx) && (al_min[i] == min_nx);
      end
   end

   // Prescaler and time-of-day: reset > set > tick.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         presc   <= '0;
         hours   <= '0;
         minutes <= '0;
         seconds <= '0;
      end else if (set) begin
         if (set_ok) begin
            presc   <= '0;
            hours   <= set_hours;
            minutes <= set_minutes;
            seconds <= set_seconds;
         end
      end else if (tick) begin
         presc   <= '0;
         hours   <= hr_nx;
         minutes <= min_nx;
         seconds <= sec_nx;
      end else if (enable) begin
         presc <= presc + PW'(1);
      end
   end

   // One-cycle status pulses that travel alongside the new time.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sec_pulse <= 1'b0;
         set_err   <= 1'b0;
      end else begin
         sec_pulse <= tick;
         set_err   <= (set && !set_ok) || (alarm_wr && sel_ok && !alarm_fields_ok);
      end
   end

   // Alarm channel settings and pending flags: write beats match, match beats ack.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         al_en         <= '0;
         alarm_pending <= '0;
         for (int i = 0; i < N_ALARMS; i++) begin
            al_hr[i]  <= '0;
            al_min[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_ALARMS; i++) begin
            if (wr_ok && (alarm_sel == SEL_W'(i))) begin
               al_hr[i]         <= alarm_hours;
               al_min[i]        <= alarm_minutes;
               al_en[i]         <= alarm_en;
               alarm_pending[i] <= 1'b0;
            end else if (match[i]) begin
               alarm_pending[i] <= 1'b1;
            end else if (ack[i]) begin
               alarm_pending[i] <= 1'b0;
            end
         end
      end
   end

   // Summary flag, registered so it trails alarm_pending by one cycle.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) alarm_any <= 1'b0;
      else       alarm_any <= |alarm_pending;
   end

endmodule
